// File: rtl/cscvon8_pkg.sv
// Shared CSCvon8 control-word encodings, field positions and sequencer states.
// The microcode assembler checks use the same definitions.
package cscvon8_pkg;

    localparam int ALU_LSB    = 0;
    localparam int LOAD_LSB   = 5;
    localparam int DBUS_LSB   = 8;
    localparam int JUMP_LSB   = 10;
    localparam int ARENA_BIT  = 12;
    localparam int PCINCR_BIT = 13;
    localparam int USRST_BIT  = 14;
    localparam int JINV_BIT   = 15;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_IR   = 3'd1,
        LD_A    = 3'd2,
        LD_B    = 3'd3,
        LD_MEM  = 3'd4,
        LD_AH   = 3'd5,
        LD_AL   = 3'd6,
        LD_IO   = 3'd7
    } load_op_e;

    typedef enum logic [1:0] {
        DB_MEM  = 2'd0,
        DB_ALU  = 2'd1,
        DB_UART = 2'd2,
        DB_BREG = 2'd3
    } dbus_op_e;

    typedef enum logic [1:0] {
        J_NONE  = 2'd0,
        J_CARRY = 2'd1,
        J_ZERO  = 2'd2,
        J_NEG   = 2'd3
    } jump_op_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_IRQ   = 2'd3
    } state_e;

endpackage

// File: rtl/useq_ctrl_jump_unit.sv
// Jump decision: selects a flag by JumpOp and optionally inverts it.
// With J_NONE the inverted form gives an unconditional jump.
module jump_unit
    import cscvon8_pkg::*;
(
    input  logic     carry,
    input  logic     zero,
    input  logic     negative,
    input  jump_op_e jump_op,
    input  logic     jump_inv,
    output logic     pcload_n
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (jump_op)
            J_NONE:  cond = 1'b0;
            J_CARRY: cond = carry;
            J_ZERO:  cond = zero;
            J_NEG:   cond = negative;
            default: cond = 1'b0;
        endcase
    end

    assign pcload_n = ~(cond ^ jump_inv);

endmodule

// File: rtl/useq_ctrl.sv
// CSCvon8 microcode sequencer: IR and microstep registers, decoder ROM index,
// and splitting of the control word into active-low strobes.
module useq_ctrl
    import cscvon8_pkg::*;
#(
    parameter int                  WordSize  = 8,
    parameter int                  UStepBits = 4,
    parameter int                  CtrlWidth = 16,
    parameter logic [WordSize-1:0] IrqOpcode = 8'hFF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [WordSize-1:0]           i_databus,
    input  logic [CtrlWidth-1:0]          i_ctrl,
    output logic [WordSize+UStepBits-1:0] o_index,
    input  logic                          i_carry,
    input  logic                          i_zero,
    input  logic                          i_negative,
    input  logic                          i_wait,
    input  logic                          i_irq,
    input  logic                          i_irq_en,
    output logic                          o_irq_ack,
    output logic [4:0]                    o_aluop,
    output logic [1:0]                    o_dbus_sel,
    output logic                          o_irload_n,
    output logic                          o_aload_n,
    output logic                          o_bload_n,
    output logic                          o_memload_n,
    output logic                          o_ahload_n,
    output logic                          o_alload_n,
    output logic                          o_ioload_n,
    output logic                          o_pcload_n,
    output logic                          o_pcincr_n,
    output logic                          o_arena_n,
    output logic                          o_ustep_err
);

    state_e               state, next_state;
    logic [WordSize-1:0]  ir;
    logic [UStepBits-1:0] us;
    logic                 ustep_err;

    load_op_e load_op;
    jump_op_e jump_op;
    logic     usreset_n, jump_pcload_n;
    logic     active, stalled, step, boundary;

    assign load_op   = load_op_e'(i_ctrl[LOAD_LSB +: 3]);
    assign jump_op   = jump_op_e'(i_ctrl[JUMP_LSB +: 2]);
    assign usreset_n = i_ctrl[USRST_BIT];

    // A pending reset suppresses every strobe, even before the edge lands.
    assign active   = ((state == ST_RUN) || (state == ST_STALL)) && !i_reset;
    assign stalled  = active && i_wait;
    assign step     = active && !i_wait;
    assign boundary = step && !usreset_n;

    jump_unit u_jump (
        .carry    (i_carry),
        .zero     (i_zero),
        .negative (i_negative),
        .jump_op  (jump_op),
        .jump_inv (i_ctrl[JINV_BIT]),
        .pcload_n (jump_pcload_n)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_RESET: next_state = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (stalled)
                    next_state = ST_STALL;
                else if (boundary && i_irq && i_irq_en)
                    next_state = ST_IRQ;
                else
                    next_state = ST_RUN;
            end
            ST_IRQ:   next_state = ST_RUN;
            default:  next_state = ST_RESET;
        endcase
    end

    always_comb begin
        o_aluop     = '0;
        o_dbus_sel  = '0;
        o_irload_n  = 1'b1;
        o_aload_n   = 1'b1;
        o_bload_n   = 1'b1;
        o_memload_n = 1'b1;
        o_ahload_n  = 1'b1;
        o_alload_n  = 1'b1;
        o_ioload_n  = 1'b1;
        o_pcload_n  = 1'b1;
        o_pcincr_n  = 1'b1;
        o_arena_n   = 1'b1;
        o_irq_ack   = (state == ST_IRQ);
        // Address-side fields keep following ctrl during a stall so memory sees a stable address.
        if (active) begin
            o_aluop    = i_ctrl[ALU_LSB +: 5];
            o_dbus_sel = i_ctrl[DBUS_LSB +: 2];
            o_arena_n  = i_ctrl[ARENA_BIT];
        end
        if (step) begin
            o_pcload_n = jump_pcload_n;
            o_pcincr_n = i_ctrl[PCINCR_BIT];
            case (load_op)
                LD_IR:   o_irload_n  = 1'b0;
                LD_A:    o_aload_n   = 1'b0;
                LD_B:    o_bload_n   = 1'b0;
                LD_MEM:  o_memload_n = 1'b0;
                LD_AH:   o_ahload_n  = 1'b0;
                LD_AL:   o_alload_n  = 1'b0;
                LD_IO:   o_ioload_n  = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_RESET;
            ir        <= '0;
            us        <= '0;
            ustep_err <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IRQ) begin
                ir <= IrqOpcode;
                us <= '0;
            end else if (step) begin
                if (load_op == LD_IR)
                    ir <= i_databus;
                if (!usreset_n) begin
                    us <= '0;
                end else begin
                    us <= us + UStepBits'(1);
                    if (us == '1)
                        ustep_err <= 1'b1;
                end
            end
        end
    end

    assign o_index     = {ir, us};
    assign o_ustep_err = ustep_err;

endmodule
